sc_ulpi_reg_engine: RTL and testbench

- Parametrised ULPI link-side register access engine for the SCBC ULPI path.
- Arbitrates register read/write requests from NUM_CH clients and sequences them onto the ULPI bus as TX CMD transfers (ULPI 3.8.2.x).
- Uses immediate addressing, or extended addressing via CPD 0x2F.
- Captures RX CMD bytes whenever the PHY owns the bus.
- Retries transfers aborted by the PHY and times out stalled ones.

---
 rtl/sc_ulpi_reg_engine.sv | 209 ++++++++++++++++++++
 tb/tb_sc_ulpi_reg_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_ulpi_reg_engine.sv
// ULPI link-side register engine: round-robin client arbitration onto ULPI TX CMD
// register reads/writes (immediate or extended address), PHY-abort retry, stall timeout, RX CMD capture.
module sc_ulpi_reg_engine #(
   parameter int NUM_CH    = 2,
   parameter int TIMEOUT   = 255,
   parameter int RETRY_MAX = 3
) (
   input  logic                ULPI_CLK,
   input  logic                ULPI_RST,
   input  logic [NUM_CH-1:0]   REQ,
   input  logic [NUM_CH-1:0]   REQ_WR,
   input  logic [8*NUM_CH-1:0] REQ_ADDR,
   input  logic [8*NUM_CH-1:0] REQ_WDATA,
   output logic [NUM_CH-1:0]   ACK,
   output logic [7:0]          RDATA,
   output logic                ERR,
   input  logic                ULPI_DIR,
   input  logic                ULPI_NXT,
   input  logic [7:0]          ULPI_DATA_I,
   output logic [7:0]          ULPI_DATA_O,
   output logic                ULPI_STP,
   output logic [7:0]          RXCMD,
   output logic                RXCMD_VLD
);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_TXCMD, S_EXTADDR, S_WDATA, S_STOP,
      S_RTURN, S_RDATA, S_RTURN2, S_ABORT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] rr_q, rr_d, ch_q, ch_d;
   logic          wr_q, wr_d;
   logic [7:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]    retry_q, retry_d;
   logic [15:0]   tmo_q, tmo_d;
   logic          err_q, err_d;
   logic          dir_q;
   logic [7:0]    rxcmd_q;
   logic          rxcmd_vld_q;

   logic          gnt_vld;
   logic [CW-1:0] gnt_idx;
   int            cand;
   logic          ext;
   logic [5:0]    cpd;
   logic          counted, tmo_hit, to_fire, abort;
   logic [7:0]    data_o;
   logic          stp_o;
   logic          rx_hit;

   // Search starts at rr_q, the channel after the last one granted.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = int'(rr_q) + i;
         if (cand >= NUM_CH) cand = cand - NUM_CH;
         if (!gnt_vld && REQ[CW'(cand)]) begin
            gnt_vld = 1'b1;
            gnt_idx = CW'(cand);
         end
      end
   end

   assign ext     = (addr_q[7:6] != 2'b00) || (addr_q == 8'h2F);
   assign cpd     = ext ? 6'h2F : addr_q[5:0];
   assign counted = (state_q == S_TXCMD) || (state_q == S_EXTADDR) || (state_q == S_WDATA) ||
                    (state_q == S_RTURN) || (state_q == S_RTURN2);
   assign tmo_hit = (tmo_q == 16'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      ch_d    = ch_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      retry_d = retry_q;
      err_d   = err_q;
      data_o  = 8'h00;
      stp_o   = 1'b0;
      to_fire = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!ULPI_DIR && gnt_vld) begin
               state_d = S_TXCMD;
               ch_d    = gnt_idx;
               rr_d    = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CW'(1);
               wr_d    = REQ_WR[gnt_idx];
               addr_d  = REQ_ADDR[{gnt_idx, 3'b000} +: 8];
               wdata_d = REQ_WDATA[{gnt_idx, 3'b000} +: 8];
               rdata_d = 8'h00;
               retry_d = 4'd0;
               err_d   = 1'b0;
            end
         end
         S_TXCMD: begin
            data_o = {1'b1, ~wr_q, cpd};
            if (ULPI_DIR)      abort   = 1'b1;
            else if (ULPI_NXT) state_d = ext ? S_EXTADDR : (wr_q ? S_WDATA : S_RTURN);
            else               to_fire = tmo_hit;
         end
         S_EXTADDR: begin
            data_o = addr_q;
            if (ULPI_DIR)      abort   = 1'b1;
            else if (ULPI_NXT) state_d = wr_q ? S_WDATA : S_RTURN;
            else               to_fire = tmo_hit;
         end
         S_WDATA: begin
            data_o = wdata_q;
            if (ULPI_DIR)      abort   = 1'b1;
            else if (ULPI_NXT) state_d = S_STOP;
            else               to_fire = tmo_hit;
         end
         S_STOP: begin
            stp_o   = 1'b1;
            state_d = S_DONE;
         end
         // DIR with NXT on the turnaround means the PHY took the bus for a receive.
         S_RTURN: begin
            if (ULPI_DIR && ULPI_NXT) abort   = 1'b1;
            else if (ULPI_DIR)        state_d = S_RDATA;
            else                      to_fire = tmo_hit;
         end
         S_RDATA: begin
            rdata_d = ULPI_DATA_I;
            state_d = S_RTURN2;
         end
         S_RTURN2: begin
            if (!ULPI_DIR) state_d = S_DONE;
            else           to_fire = tmo_hit;
         end
         S_ABORT: begin
            if (!ULPI_DIR) begin
               if (int'(retry_q) > RETRY_MAX) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_TXCMD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_ABORT;
         retry_d = retry_q + 4'd1;
      end
      if (to_fire) begin
         err_d   = 1'b1;
         rdata_d = 8'h00;
         state_d = ULPI_DIR ? S_DONE : S_STOP;
      end
   end

   assign tmo_d  = (counted && (state_d == state_q)) ? tmo_q + 16'd1 : 16'd0;
   assign rx_hit = ULPI_DIR && dir_q && !ULPI_NXT && (state_q != S_RDATA);

   always_ff @(posedge ULPI_CLK) begin
      if (ULPI_RST) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         ch_q        <= '0;
         wr_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         retry_q     <= 4'd0;
         tmo_q       <= 16'd0;
         err_q       <= 1'b0;
         dir_q       <= 1'b0;
         rxcmd_q     <= 8'h00;
         rxcmd_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         ch_q        <= ch_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         retry_q     <= retry_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         dir_q       <= ULPI_DIR;
         rxcmd_q     <= rx_hit ? ULPI_DATA_I : rxcmd_q;
         rxcmd_vld_q <= rx_hit;
      end
   end

   always_comb begin
      ACK = '0;
      if (state_q == S_DONE) ACK[ch_q] = 1'b1;
   end

   assign ERR         = (state_q == S_DONE) && err_q;
   assign RDATA       = rdata_q;
   assign ULPI_DATA_O = ULPI_DIR ? 8'h00 : data_o;
   assign ULPI_STP    = stp_o;
   assign RXCMD       = rxcmd_q;
   assign RXCMD_VLD   = rxcmd_vld_q;
endmodule

// File: tb/tb_sc_ulpi_reg_engine.sv
// Bench for sc_ulpi_reg_engine: directed ULPI scenarios plus randomized client traffic
// against a PHY/client model that derives expected bus bytes and grant order from address rules.
module tb_sc_ulpi_reg_engine;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, req_wr, ack;
   logic [15:0] req_addr, req_wdata;
   logic [7:0]  rdata, din, dout, rxcmd;
   logic        err, dir, nxt, stp, rxcmd_vld;

   int checks = 0;
   int errors = 0;

   logic [1:0] pend;
   logic       m_wr[2];
   logic [7:0] m_addr[2], m_wd[2], m_rb[2];
   logic       m_next;

   sc_ulpi_reg_engine #(.NUM_CH(2), .TIMEOUT(16), .RETRY_MAX(3)) dut (
      .ULPI_CLK(clk), .ULPI_RST(rst), .REQ(req), .REQ_WR(req_wr),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .ACK(ack), .RDATA(rdata), .ERR(err),
      .ULPI_DIR(dir), .ULPI_NXT(nxt), .ULPI_DATA_I(din), .ULPI_DATA_O(dout),
      .ULPI_STP(stp), .RXCMD(rxcmd), .RXCMD_VLD(rxcmd_vld)
   );

   always #8 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req();
      req       = pend;
      req_wr    = {m_wr[1], m_wr[0]};
      req_addr  = {m_addr[1], m_addr[0]};
      req_wdata = {m_wd[1], m_wd[0]};
   endtask

   task automatic rand_client(input logic c);
      int sel;
      sel       = $urandom_range(3, 0);
      m_wr[c]   = 1'($urandom_range(1, 0));
      m_addr[c] = (sel == 0) ? 8'h2F : (sel == 1) ? 8'($urandom_range(63, 0)) : 8'($urandom);
      m_wd[c]   = 8'($urandom);
      m_rb[c]   = 8'($urandom);
   endtask

   // Plays the PHY for one transfer of the channel the round-robin model expects to win.
   task automatic serve(input bit keep, input int dmax, output logic [1:0] ack_got);
      logic       w;
      logic [7:0] q[$];
      bit         imm, seen;
      int         d;
      ack_got = 2'b00;
      w   = pend[m_next] ? m_next : ~m_next;
      imm = (m_addr[w] < 8'h40) && (m_addr[w] != 8'h2F);
      q.push_back((m_wr[w] ? 8'h80 : 8'hC0) + (imm ? m_addr[w] : 8'h2F));
      if (!imm) q.push_back(m_addr[w]);
      if (m_wr[w]) q.push_back(m_wd[w]);
      drive_req();
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         seen = dout[7];
      end
      chk("txcmd_seen", 32'(seen), 32'd1);
      if (!seen) begin
         pend[w] = 1'b0;
         drive_req();
         return;
      end
      chk("ack_idle", 32'(ack), 32'd0);
      foreach (q[k]) begin
         d = $urandom_range(dmax, 0);
         for (int j = 0; j <= d; j++) begin
            chk("bus_byte", 32'(dout), 32'(q[k]));
            nxt = (j == d);
            @(negedge clk);
         end
         nxt = 1'b0;
      end
      if (m_wr[w]) begin
         chk("stop_stp", 32'(stp), 32'd1);
         chk("stop_data", 32'(dout), 32'd0);
         @(negedge clk);
      end else begin
         d = $urandom_range(dmax, 0);
         repeat (d) begin
            chk("rturn_data", 32'(dout), 32'd0);
            @(negedge clk);
         end
         dir = 1'b1;
         @(negedge clk);
         din = m_rb[w];
         @(negedge clk);
         din = 8'h00;
         dir = 1'b0;
         @(negedge clk);
         chk("rdata", 32'(rdata), 32'(m_rb[w]));
      end
      ack_got = ack;
      chk("ack", 32'(ack), w ? 32'd2 : 32'd1);
      chk("err", 32'(err), 32'd0);
      chk("stp_low", 32'(stp), 32'd0);
      m_next = ~w;
      if (!keep) pend[w] = 1'b0;
      drive_req();
   endtask

   initial begin
      logic [1:0] ag;
      int         attempts, cnt, vcnt, acks;
      bit         done, seen;

      rst = 1'b1; dir = 1'b0; nxt = 1'b0; din = 8'h00; pend = 2'b00;
      for (int c = 0; c < 2; c++) begin
         m_wr[c] = 1'b0; m_addr[c] = 8'h00; m_wd[c] = 8'h00; m_rb[c] = 8'h00;
      end
      m_next = 1'b0;
      drive_req();
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_stp", 32'(stp), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_rxcmd", 32'(rxcmd), 32'd0);
      chk("rst_rxvld", 32'(rxcmd_vld), 32'd0);
      rst = 1'b0;

      // Immediate write, immediate read, extended write
      pend = 2'b01; m_wr[0] = 1'b1; m_addr[0] = 8'h04; m_wd[0] = 8'h45;
      serve(1'b0, 0, ag);
      pend = 2'b10; m_wr[1] = 1'b0; m_addr[1] = 8'h16; m_rb[1] = 8'hA5;
      serve(1'b0, 0, ag);
      pend = 2'b01; m_wr[0] = 1'b1; m_addr[0] = 8'h81; m_wd[0] = 8'h12;
      serve(1'b0, 0, ag);

      // Both clients held: grants alternate from channel 0 after reset
      rst = 1'b1; @(negedge clk); rst = 1'b0; m_next = 1'b0;
      m_wr[0] = 1'b1; m_addr[0] = 8'h30; m_wd[0] = 8'h11;
      m_wr[1] = 1'b0; m_addr[1] = 8'h55; m_rb[1] = 8'h99;
      pend = 2'b11;
      for (int i = 0; i < 4; i++) begin
         serve(1'b1, 1, ag);
         chk("rr_order", 32'(ag), (i % 2 == 1) ? 32'd2 : 32'd1);
      end
      pend = 2'b00; drive_req();

      // PHY aborts every WDATA phase
      pend = 2'b01; m_wr[0] = 1'b1; m_addr[0] = 8'h04; m_wd[0] = 8'h5A; drive_req();
      attempts = 0; done = 1'b0;
      for (int t = 0; t < 60 && !done; t++) begin
         @(negedge clk);
         if (ack != 2'b00) begin
            done = 1'b1;
         end else if (dout == 8'h84) begin
            attempts++;
            nxt = 1'b1;
            @(negedge clk);
            nxt = 1'b0;
            chk("abort_wdata", 32'(dout), 32'h5A);
            dir = 1'b1;
            @(negedge clk);
            chk("abort_drive_off", 32'(dout), 32'd0);
            dir = 1'b0;
         end
      end
      chk("abort_done", 32'(done), 32'd1);
      chk("abort_attempts", 32'(attempts), 32'd4);
      chk("abort_ack", 32'(ack), 32'd1);
      chk("abort_err", 32'(err), 32'd1);
      pend = 2'b00; drive_req(); m_next = 1'b1;

      // NXT never comes: timeout after 16 TXCMD cycles
      pend = 2'b10; m_wr[1] = 1'b0; m_addr[1] = 8'h16; drive_req();
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         seen = dout[7];
      end
      cnt = 0;
      for (int t = 0; t < 40; t++) begin
         if (stp) break;
         if (dout == 8'hD6) cnt++;
         @(negedge clk);
      end
      chk("tmo_stp", 32'(stp), 32'd1);
      chk("tmo_cycles", 32'(cnt), 32'd16);
      @(negedge clk);
      chk("tmo_ack", 32'(ack), 32'd2);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_rdata", 32'(rdata), 32'd0);
      pend = 2'b00; drive_req(); m_next = 1'b0;

      // RX CMD while a request waits behind DIR=1
      @(negedge clk);
      pend = 2'b01; m_wr[0] = 1'b1; m_addr[0] = 8'h2F; m_wd[0] = 8'h3C; drive_req();
      dir = 1'b1; din = 8'h4E; vcnt = 0;
      for (int t = 1; t <= 3; t++) begin
         @(negedge clk);
         if (rxcmd_vld) vcnt++;
         chk("rx_no_ack", 32'(ack), 32'd0);
         if (t == 3) begin
            dir = 1'b0;
            din = 8'h00;
         end
      end
      chk("rx_vld_count", 32'(vcnt), 32'd2);
      chk("rx_value", 32'(rxcmd), 32'h4E);
      serve(1'b0, 1, ag);

      // Randomized client traffic
      for (int it = 0; it < 24; it++) begin
         rand_client(1'b0);
         rand_client(1'b1);
         pend = 2'($urandom_range(3, 1));
         for (int k = 0; k < 2 && pend != 2'b00; k++) serve(1'b0, 2, ag);
      end

      // Reset mid-transfer loses the transfer
      pend = 2'b01; m_wr[0] = 1'b1; m_addr[0] = 8'h0A; m_wd[0] = 8'h77; drive_req();
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         seen = dout[7];
      end
      chk("rstmid_txcmd", 32'(seen), 32'd1);
      rst = 1'b1; pend = 2'b00; drive_req();
      @(negedge clk);
      chk("rstmid_dout", 32'(dout), 32'd0);
      chk("rstmid_stp", 32'(stp), 32'd0);
      chk("rstmid_ack", 32'(ack), 32'd0);
      rst = 1'b0;
      acks = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack != 2'b00) acks++;
      end
      chk("rstmid_no_ack", 32'(acks), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
